green_led_pwm_driver: RTL and testbench
=======================================

# green_led_pwm_driver

Downstream consumer of the green-LED PIO's 8-bit `out_port`, driving the board's eight green LEDs. Applies a global brightness PWM and per-bit blink to the PIO value. PIO and brightness updates are adopted only at PWM period boundaries, so software writes never produce runt pulses on the LEDs. Single clock domain, same `clk` as the Avalon fabric.

## Interface
- `PWM_BITS`, default 8: width of the PWM counter and of `brightness`; period = 2^PWM_BITS ticks.
- `PRESCALE`, default 16: clk cycles per PWM tick. Legal range is ≥1; 1 means a tick every cycle.
- `BLINK_PERIODS`, default 64: PWM periods per blink half-cycle. Legal range is ≥1.
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `led_in`, in, 8: LED value from the PIO `out_port` (same clock domain, no synchroniser).
- `brightness`, in, PWM_BITS: duty setting. 0 = off; all-ones = 100 % on.
- `blink_mask`, in, 8: bits set here blink; bits clear are steady.
- `led_out`, out, 8: registered LED drive, 1 = lit.
- `period_start`, out, 1: one-cycle pulse on the cycle after each PWM period boundary (observability/test).

## Operation
- Prescaler `pre_cnt` counts 0..PRESCALE-1 and wraps. `tick` = (`pre_cnt` == PRESCALE-1).
- PWM counter `pwm_cnt` (PWM_BITS wide) increments on `tick` and wraps from 2^PWM_BITS-1 to 0.
- Period boundary `bnd` = `tick` && `pwm_cnt` == all-ones. At the `bnd` edge:
  - `led_act` <= `led_in`, `bri_act` <= `brightness`, `mask_act` <= `blink_mask`.
  - `blink_cnt` increments. When it reaches BLINK_PERIODS-1 it wraps to 0 and `blink_ph` toggles.
- Shadow registers change at no other time. Input changes mid-period are ignored until the next `bnd`; only the value present at the `bnd` edge is taken.
- Duty logic, evaluated from active registers:
  - `on` = (`bri_act` == all-ones) ? 1 : (`pwm_cnt` < `bri_act`).
  - Unsigned compare at PWM_BITS width. No overflow is possible.
- Every cycle: `led_out` <= `led_act` & {8{`on`}} & ~(`mask_act` & {8{`blink_ph`}}).
- `period_start` <= `bnd` every cycle.
- Reset asserted mid-period: all state clears immediately, with no completion of the current period.

## Timing
- Reset values: `led_out`=0, `period_start`=0, `pre_cnt`=0, `pwm_cnt`=0, `blink_cnt`=0, `blink_ph`=0, `led_act`=0, `bri_act`=0, `mask_act`=0.
  - Consequence: LEDs stay dark until the first boundary, i.e. PRESCALE·2^PWM_BITS cycles after reset release.
- Boundary timing: `bnd` is true in the cycle where `pre_cnt`=PRESCALE-1 and `pwm_cnt`=max. The first `bnd` after reset is cycle PRESCALE·2^PWM_BITS − 1, counting from 0 at the first edge after release.
- Input latency: a change on `led_in` or `brightness` reaches `led_out` at the edge after the first `bnd` edge at or after the change. Worst case is one full period plus one cycle.
- Output timing: `led_out` is registered, so it lags the `pwm_cnt` state it reflects by one cycle.
  - Lit duty per period = `bri_act` ticks × PRESCALE cycles, or the full period for all-ones.
- Blink: each half-cycle lasts BLINK_PERIODS periods. The first toggle of `blink_ph` occurs at the BLINK_PERIODS-th boundary after reset.
- `led_in` changing in the exact `bnd` cycle: the new value is captured.
- `period_start` pulses exactly once per period, with spacing PRESCALE·2^PWM_BITS cycles.

## Test plan
All scenarios use PWM_BITS=4, PRESCALE=2, BLINK_PERIODS=2 (period = 32 cycles).
- **Reset:** hold `reset_n`=0 with `led_in`=FF, `brightness`=F.
  - → `led_out`=00 and `period_start`=0 through reset and through the first 31 cycles after release.
  - → First `period_start` pulse at cycle 32.
- **Half duty:** `led_in`=A5, `brightness`=8, `blink_mask`=00.
  - → After the first boundary, every period shows `led_out`=A5 for 16 cycles, then 00 for 16 cycles.
- **Duty extremes:** `brightness`=0 → `led_out` constantly 00. `brightness`=F → `led_out` constantly A5, with no gap at wrap.
- **Mid-period write:** change `led_in` A5→3C 5 cycles after a `period_start`.
  - → `led_out` keeps A5 timing until the next boundary, then shows 3C one cycle after it.
  - → No partial pulse appears on any bit.
- **Blink:** `led_in`=FF, `brightness`=F, `blink_mask`=0F.
  - → `led_out`=FF for 2 periods, F0 for 2 periods, repeating.
- **Reset mid-operation:** assert `reset_n` low at cycle 10 of a lit period.
  - → `led_out`=00 asynchronously.
  - → After release, timing restarts exactly as in the Reset scenario.

Source files
------------

// File: rtl/green_led_pwm_driver.sv
// Green LED driver: global brightness PWM plus per-bit blink on the PIO value.
// PIO, brightness and blink mask are adopted only at PWM period boundaries.
module green_led_pwm_driver #(
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned PRESCALE      = 16,
    parameter int unsigned BLINK_PERIODS = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          led_in,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic [7:0]          blink_mask,
    output logic [7:0]          led_out,
    output logic                period_start
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_PERIODS - 1);

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BLK_W-1:0]    blink_cnt;
    logic                blink_ph;
    logic [7:0]          led_act;
    logic [PWM_BITS-1:0] bri_act;
    logic [7:0]          mask_act;

    logic       tick;
    logic       bnd;
    logic       pwm_on;
    logic [7:0] led_nxt;

    // Tick, period boundary and the LED value for the next cycle
    always_comb begin
        tick    = (pre_cnt == PRE_LAST);
        bnd     = tick && (&pwm_cnt);
        pwm_on  = (&bri_act) ? 1'b1 : (pwm_cnt < bri_act);
        led_nxt = led_act & {8{pwm_on}} & ~(mask_act & {8{blink_ph}});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt      <= '0;
            pwm_cnt      <= '0;
            blink_cnt    <= '0;
            blink_ph     <= 1'b0;
            led_act      <= '0;
            bri_act      <= '0;
            mask_act     <= '0;
            led_out      <= '0;
            period_start <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
            // Shadow registers move only at the boundary so updates never cut a pulse short
            if (bnd) begin
                led_act  <= led_in;
                bri_act  <= brightness;
                mask_act <= blink_mask;
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    blink_cnt <= blink_cnt + BLK_W'(1);
                end
            end
            led_out      <= led_nxt;
            period_start <= bnd;
        end
    end

endmodule

// File: tb/tb_green_led_pwm_driver.sv
// Directed bench for green_led_pwm_driver with PWM_BITS=4, PRESCALE=2, BLINK_PERIODS=2.
module tb_green_led_pwm_driver;

    logic       clk;
    logic       reset_n;
    logic [7:0] led_in;
    logic [3:0] brightness;
    logic [7:0] blink_mask;
    logic [7:0] led_out;
    logic       period_start;

    int unsigned errors = 0;
    int unsigned checks = 0;

    green_led_pwm_driver #(
        .PWM_BITS     (4),
        .PRESCALE     (2),
        .BLINK_PERIODS(2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .led_in      (led_in),
        .brightness  (brightness),
        .blink_mask  (blink_mask),
        .led_out     (led_out),
        .period_start(period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starting at a period_start cycle, walk one 32-cycle period.
    // lit_cycles: cycles led_out shows 'lit' before going dark; wr_k: step at which led_in <= wr_val.
    task automatic run_period(input string tag, input logic [7:0] lit, input int unsigned lit_cycles,
                              input int unsigned wr_k, input logic [7:0] wr_val);
        for (int k = 1; k <= 32; k++) begin
            step();
            chk({tag, "_led"}, led_out, (k <= int'(lit_cycles)) ? lit : 8'h00);
            chk({tag, "_ps"}, {7'b0, period_start}, (k == 32) ? 8'h01 : 8'h00);
            if (k == int'(wr_k)) led_in = wr_val;
        end
    endtask

    // Post-release sequence: dark and quiet for 31 cycles, first pulse at cycle 32.
    task automatic after_release(input string tag);
        for (int n = 1; n <= 31; n++) begin
            step();
            chk({tag, "_led_dark"}, led_out, 8'h00);
            chk({tag, "_ps_quiet"}, {7'b0, period_start}, 8'h00);
        end
        step();
        chk({tag, "_first_ps"}, {7'b0, period_start}, 8'h01);
        chk({tag, "_led_at_bnd"}, led_out, 8'h00);
    endtask

    initial begin
        reset_n    = 1'b0;
        led_in     = 8'hFF;
        brightness = 4'hF;
        blink_mask = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_led", led_out, 8'h00);
        chk("reset_ps", {7'b0, period_start}, 8'h00);
        reset_n = 1'b1;

        // Inputs for the first period are set before the first boundary
        led_in     = 8'hA5;
        brightness = 4'h8;
        after_release("rst1");

        run_period("half1", 8'hA5, 16, 0, 8'h00);
        brightness = 4'h0;
        run_period("half2", 8'hA5, 16, 0, 8'h00);
        brightness = 4'hF;
        run_period("bri0", 8'hA5, 0, 0, 8'h00);
        run_period("briF_a", 8'hA5, 32, 0, 8'h00);
        run_period("midwr", 8'hA5, 32, 5, 8'h3C);
        led_in     = 8'hFF;
        blink_mask = 8'h0F;
        run_period("after_wr", 8'h3C, 32, 0, 8'h00);

        // blink_ph toggles at boundaries 2,4,6,...; periods 7..11 follow
        run_period("blink7", 8'hF0, 32, 0, 8'h00);
        run_period("blink8", 8'hFF, 32, 0, 8'h00);
        run_period("blink9", 8'hFF, 32, 0, 8'h00);
        run_period("blink10", 8'hF0, 32, 0, 8'h00);
        run_period("blink11", 8'hF0, 32, 0, 8'h00);

        // Period 12 is fully lit; reset lands at cycle 10 of it
        for (int k = 1; k <= 10; k++) step();
        chk("pre_reset_lit", led_out, 8'hFF);
        reset_n = 1'b0;
        #1;
        chk("async_reset_led", led_out, 8'h00);
        chk("async_reset_ps", {7'b0, period_start}, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("hold_reset_led", led_out, 8'h00);
        reset_n = 1'b1;
        after_release("rst2");
        step();
        chk("rst2_first_lit", led_out, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
